// File: rtl/wb_rr_arbiter.sv
// Round-robin N-master to 1-slave Wishbone arbiter; grant is registered and held for the owner's whole cycle.
// Define WB_ARB_TIMEOUT_EN to build the stalled-access timeout that raises m_wb_err_o to the owner.
//
// state | meaning
// IDLE  | no owner; pick the next requester after 'last' on the coming edge
// BUSY  | 'owner' drives the slave port until it drops cyc
module wb_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_i,
   input  logic [NUM_MASTERS-1:0]        m_wb_cyc_i,
   input  logic [NUM_MASTERS-1:0]        m_wb_stb_i,
   input  logic [NUM_MASTERS-1:0]        m_wb_we_i,
   input  logic [4*NUM_MASTERS-1:0]      m_wb_sel_i,
   input  logic [ADDR_W*NUM_MASTERS-1:0] m_wb_adr_i,
   input  logic [32*NUM_MASTERS-1:0]     m_wb_dat_i,
   output logic [31:0]                   m_wb_dat_o,
   output logic [NUM_MASTERS-1:0]        m_wb_ack_o,
   output logic [NUM_MASTERS-1:0]        m_wb_err_o,
   output logic                          s_wb_cyc_o,
   output logic                          s_wb_stb_o,
   output logic                          s_wb_we_o,
   output logic [3:0]                    s_wb_sel_o,
   output logic [ADDR_W-1:0]             s_wb_adr_o,
   output logic [31:0]                   s_wb_dat_o,
   input  logic [31:0]                   s_wb_dat_i,
   input  logic                          s_wb_ack_i
);

   localparam int OWN_W = $clog2(NUM_MASTERS);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
      $error("wb_rr_arbiter: NUM_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_rr_arbiter: TIMEOUT_CYCLES must be 1..65535");
   end

   logic [0:0]       state;
   logic [OWN_W-1:0] owner;
   logic [OWN_W-1:0] last;
   logic [OWN_W-1:0] pick_idx;
   logic             busy;
   logic             owner_cyc;
   logic             owner_stb;
   logic             timeout_hit;
   logic             mux_we;
   logic [3:0]       mux_sel;
   logic [ADDR_W-1:0] mux_adr;
   logic [31:0]      mux_dat;

   assign busy = (state == ST_BUSY);

   // Lowest requester above 'last' wins; otherwise wrap to the lowest at or below it.
   always_comb begin
      pick_idx = '0;
      for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
         if (m_wb_cyc_i[j] && (OWN_W'(j) <= last)) begin
            pick_idx = OWN_W'(j);
         end
      end
      for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
         if (m_wb_cyc_i[j] && (OWN_W'(j) > last)) begin
            pick_idx = OWN_W'(j);
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= ST_IDLE;
         owner <= '0;
         last  <= OWN_W'(NUM_MASTERS - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (|m_wb_cyc_i) begin
                  owner <= pick_idx;
                  last  <= pick_idx;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!owner_cyc) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      owner_cyc = 1'b0;
      owner_stb = 1'b0;
      mux_we    = 1'b0;
      mux_sel   = '0;
      mux_adr   = '0;
      mux_dat   = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (owner == OWN_W'(k)) begin
            owner_cyc = m_wb_cyc_i[k];
            owner_stb = m_wb_cyc_i[k] & m_wb_stb_i[k];
            mux_we    = m_wb_we_i[k];
            mux_sel   = m_wb_sel_i[4*k +: 4];
            mux_adr   = m_wb_adr_i[ADDR_W*k +: ADDR_W];
            mux_dat   = m_wb_dat_i[32*k +: 32];
         end
      end
   end

   assign s_wb_cyc_o = busy & owner_cyc;
   assign s_wb_stb_o = busy & owner_stb & ~timeout_hit;
   assign s_wb_we_o  = busy & mux_we;
   assign s_wb_sel_o = busy ? mux_sel : '0;
   assign s_wb_adr_o = busy ? mux_adr : '0;
   assign s_wb_dat_o = busy ? mux_dat : '0;

   assign m_wb_dat_o = s_wb_dat_i;

   // Slave ack goes straight to the owner, including acks that arrive without a strobe.
   always_comb begin
      m_wb_ack_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (busy && (owner == OWN_W'(k))) begin
            m_wb_ack_o[k] = s_wb_ack_i;
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] stall_cnt;
   logic        stall;

   assign stall       = busy & owner_stb & ~s_wb_ack_i;
   assign timeout_hit = stall & (stall_cnt == 16'(TIMEOUT_CYCLES - 1));

   // The raw owner strobe feeds the stall detect so forcing stb low cannot loop back.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !busy || !owner_cyc || s_wb_ack_i || timeout_hit) begin
         stall_cnt <= '0;
      end else if (stall) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

   always_comb begin
      m_wb_err_o = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (owner == OWN_W'(k)) begin
            m_wb_err_o[k] = timeout_hit;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign m_wb_err_o  = '0;
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Scoreboard bench for wb_rr_arbiter (3 masters): expected grants and acks are queued by
// the stimulus and popped by a negedge monitor whenever the DUT grants, acks or errors.
module tb_wb_rr_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  m_cyc, m_stb, m_we;
   logic [4*N-1:0]  m_sel;
   logic [32*N-1:0] m_adr, m_dat;
   logic [31:0]   m_dat_o;
   logic [N-1:0]  m_ack, m_err;
   logic          s_cyc, s_stb, s_we;
   logic [3:0]    s_sel;
   logic [31:0]   s_adr, s_dat_o;
   logic [31:0]   s_dat = '0;
   logic          s_ack = 1'b0;
   logic          slave_en;

   typedef struct {
      logic [N-1:0] ack;
      logic [N-1:0] err;
      logic [31:0]  dat;
   } resp_t;

   resp_t       exp_q[$];
   logic [31:0] grant_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .m_wb_cyc_i (m_cyc),
      .m_wb_stb_i (m_stb),
      .m_wb_we_i  (m_we),
      .m_wb_sel_i (m_sel),
      .m_wb_adr_i (m_adr),
      .m_wb_dat_i (m_dat),
      .m_wb_dat_o (m_dat_o),
      .m_wb_ack_o (m_ack),
      .m_wb_err_o (m_err),
      .s_wb_cyc_o (s_cyc),
      .s_wb_stb_o (s_stb),
      .s_wb_we_o  (s_we),
      .s_wb_sel_o (s_sel),
      .s_wb_adr_o (s_adr),
      .s_wb_dat_o (s_dat_o),
      .s_wb_dat_i (s_dat),
      .s_wb_ack_i (s_ack)
   );

   always #5 clk = ~clk;

   // Slave model: one-cycle registered ack per strobe, read data is the inverted address.
   always @(posedge clk) begin
      if (rst || !slave_en) begin
         s_ack <= 1'b0;
      end else if (s_stb && !s_ack) begin
         s_ack <= 1'b1;
         s_dat <= ~s_adr;
      end else begin
         s_ack <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] adr_of(input int tag, input int k, input int j);
      return 32'h1000_0000 | (32'(tag) << 16) | (32'(k) << 8) | (32'(j) << 2);
   endfunction

   task automatic set_master(input int k, input logic cyc, input logic stb, input logic we,
                             input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
      m_cyc[k] = cyc;
      m_stb[k] = stb;
      m_we[k]  = we;
      m_sel[4*k +: 4]   = sel;
      m_adr[32*k +: 32] = adr;
      m_dat[32*k +: 32] = dat;
   endtask

   task automatic drop_master(input int k);
      set_master(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic push_ack(input int k, input logic [31:0] adr);
      resp_t e;
      e.ack = '0;
      e.ack[k] = 1'b1;
      e.err = '0;
      e.dat = ~adr;
      exp_q.push_back(e);
   endtask

   task automatic wait_flag(input int k, input bit want_err);
      bit seen = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         @(negedge clk);
         if (want_err ? m_err[k] : m_ack[k]) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_%s_m%0d: not seen, required within 80 cycles", want_err ? "err" : "ack", k);
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < N; k++) drop_master(k);
      slave_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic check_handover(input string name, input logic [31:0] exp_adr);
      @(negedge clk);
      check({name, "_release"}, 32'(s_cyc), 32'd0);
      @(negedge clk);
      check({name, "_dead"}, 32'(s_cyc), 32'd0);
      @(negedge clk);
      check({name, "_grant"}, 32'(s_cyc), 32'd1);
      check({name, "_adr"}, s_adr, exp_adr);
   endtask

   task automatic rr_master(input int k);
      for (int j = 0; j < 2; j++) begin
         set_master(k, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(3, k, j), 32'h0);
         wait_flag(k, 1'b0);
         @(posedge clk); #1;
         drop_master(k);
         @(posedge clk); #1;
      end
   endtask

   // Monitor: new grants pop grant_q, any ack/err pops exp_q.
   initial begin : monitor
      logic  prev_cyc;
      resp_t e;
      logic [31:0] g;
      prev_cyc = 1'b0;
      forever begin
         @(negedge clk);
         if (s_cyc && !prev_cyc) begin
            if (grant_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_grant: adr %h, required no grant", s_adr);
            end else begin
               g = grant_q.pop_front();
               check("grant_adr", s_adr, g);
            end
         end
         prev_cyc = s_cyc;
         if ((|m_ack) || (|m_err)) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_resp: ack %b err %b, required none", m_ack, m_err);
            end else begin
               e = exp_q.pop_front();
               check("resp_ack", 32'(m_ack), 32'(e.ack));
               check("resp_err", 32'(m_err), 32'(e.err));
               if (|e.ack) check("resp_dat", m_dat_o, e.dat);
               if (|m_err) check("err_stb_forced_low", 32'(s_stb), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst = 1'b1;
      slave_en = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_s_cyc", 32'(s_cyc), 32'd0);
      check("rst_s_stb", 32'(s_stb), 32'd0);
      check("rst_ack", 32'(m_ack), 32'd0);
      check("rst_err", 32'(m_err), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Single M0 write
      grant_q.push_back(adr_of(1, 0, 0));
      push_ack(0, adr_of(1, 0, 0));
      set_master(0, 1'b1, 1'b1, 1'b1, 4'b0001, adr_of(1, 0, 0), 32'h1);
      @(negedge clk);
      check("w_stb_before_grant", 32'(s_stb), 32'd0);
      @(negedge clk);
      check("w_stb_granted", 32'(s_stb), 32'd1);
      check("w_we", 32'(s_we), 32'd1);
      check("w_sel", 32'(s_sel), 32'h1);
      check("w_dat", s_dat_o, 32'h1);
      wait_flag(0, 1'b0);
      @(posedge clk); #1;
      drop_master(0);
      repeat (3) @(posedge clk);

      // Simultaneous M0/M1 after reset
      do_reset();
      grant_q.push_back(adr_of(2, 0, 0));
      grant_q.push_back(adr_of(2, 1, 0));
      push_ack(0, adr_of(2, 0, 0));
      push_ack(1, adr_of(2, 1, 0));
      set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(2, 0, 0), 32'h0);
      set_master(1, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(2, 1, 0), 32'h0);
      wait_flag(0, 1'b0);
      @(posedge clk); #1;
      drop_master(0);
      check_handover("sim", adr_of(2, 1, 0));
      wait_flag(1, 1'b0);
      @(posedge clk); #1;
      drop_master(1);
      repeat (3) @(posedge clk);

      // Three continuous requesters: 0,1,2,0,1,2
      do_reset();
      for (int j = 0; j < 2; j++) begin
         for (int k = 0; k < N; k++) begin
            grant_q.push_back(adr_of(3, k, j));
            push_ack(k, adr_of(3, k, j));
         end
      end
      fork
         rr_master(0);
         rr_master(1);
         rr_master(2);
      join
      repeat (3) @(posedge clk);

      // M1 block transfer of 3 strobes with M0 pending
      do_reset();
      grant_q.push_back(adr_of(4, 1, 0));
      grant_q.push_back(adr_of(4, 0, 0));
      for (int s = 0; s < 3; s++) push_ack(1, adr_of(4, 1, s));
      push_ack(0, adr_of(4, 0, 0));
      set_master(1, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(4, 1, 0), 32'h0);
      @(posedge clk); #1;
      set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(4, 0, 0), 32'h0);
      for (int s = 0; s < 3; s++) begin
         wait_flag(1, 1'b0);
         @(posedge clk); #1;
         if (s < 2) set_master(1, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(4, 1, s + 1), 32'h0);
         else drop_master(1);
      end
      check_handover("blk", adr_of(4, 0, 0));
      wait_flag(0, 1'b0);
      @(posedge clk); #1;
      drop_master(0);
      repeat (3) @(posedge clk);

      // Reset while M1 is mid-access with the slave silent
      do_reset();
      slave_en = 1'b0;
      grant_q.push_back(adr_of(5, 1, 0));
      grant_q.push_back(adr_of(5, 1, 0));
      push_ack(1, adr_of(5, 1, 0));
      set_master(1, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(5, 1, 0), 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("mrst_busy_before", 32'(s_cyc), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("mrst_s_cyc", 32'(s_cyc), 32'd0);
      check("mrst_s_stb", 32'(s_stb), 32'd0);
      check("mrst_ack", 32'(m_ack), 32'd0);
      @(negedge clk);
      check("mrst_regrant", 32'(s_cyc), 32'd1);
      @(posedge clk); #1;
      slave_en = 1'b1;
      wait_flag(1, 1'b0);
      @(posedge clk); #1;
      drop_master(1);
      repeat (3) @(posedge clk);

`ifdef WB_ARB_TIMEOUT_EN
      // Slave never acks: one err pulse after 4 stalled cycles, grant kept until cyc drops
      do_reset();
      slave_en = 1'b0;
      begin
         resp_t e;
         e.ack = '0;
         e.err = 3'b001;
         e.dat = '0;
         exp_q.push_back(e);
      end
      grant_q.push_back(adr_of(6, 0, 0));
      set_master(0, 1'b1, 1'b1, 1'b0, 4'hF, adr_of(6, 0, 0), 32'h0);
      wait_flag(0, 1'b1);
      @(posedge clk); #1;
      m_stb[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("to_grant_held", 32'(s_cyc), 32'd1);
      end
      @(posedge clk); #1;
      drop_master(0);
      slave_en = 1'b1;
      repeat (3) @(posedge clk);
`endif

      repeat (4) @(posedge clk);
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      check("grant_q_drained", 32'(grant_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- N-master to 1-slave Wishbone arbiter with round-robin fairness.
- Shares a single peripheral (e.g. the GPIO slave) between the CPU data port and secondary masters (DMA, debug).
- Sits between the masters and the peripheral's Wishbone port.
- Grant is registered and held for the owner's whole bus cycle (cyc high).

Parameters:
- NUM_MASTERS, 2, number of requesting masters; legal range 2..8.
- ADDR_W, 32, address width per master.
- TIMEOUT_CYCLES, 255, stalled-access limit; used only with the optional feature; legal range 1..65535.

Ports:
- wb_clk_i  in  1  clock; all logic on posedge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m_wb_cyc_i  in  NUM_MASTERS  per-master bus-cycle request.
- m_wb_stb_i  in  NUM_MASTERS  per-master strobe.
- m_wb_we_i  in  NUM_MASTERS  per-master write enable.
- m_wb_sel_i  in  4*NUM_MASTERS  byte selects; master k at [4k+3:4k].
- m_wb_adr_i  in  ADDR_W*NUM_MASTERS  addresses; master k slice k.
- m_wb_dat_i  in  32*NUM_MASTERS  write data; master k slice k.
- m_wb_dat_o  out  32  read data, broadcast to all masters.
- m_wb_ack_o  out  NUM_MASTERS  per-master ack.
- m_wb_err_o  out  NUM_MASTERS  per-master error; constant 0 without the optional feature.
- s_wb_cyc_o  out  1  slave cycle.
- s_wb_stb_o  out  1  slave strobe.
- s_wb_we_o  out  1  slave write enable.
- s_wb_sel_o  out  4  slave byte selects.
- s_wb_adr_o  out  ADDR_W  slave address.
- s_wb_dat_o  out  32  slave write data.
- s_wb_dat_i  in  32  slave read data.
- s_wb_ack_i  in  1  slave ack.

Behaviour:
- Registers:
  - state: IDLE / BUSY.
  - owner: index of the granted master, clog2(NUM_MASTERS) bits.
  - last: index of the most recently granted master.
- Reset (applies at any time, including mid-transfer):
  - state=IDLE, owner=0, last=NUM_MASTERS-1, so master 0 has top priority.
  - Resulting outputs: s_wb_cyc_o=0, s_wb_stb_o=0, all m_wb_ack_o=0, all m_wb_err_o=0.
  - Any in-flight slave access is abandoned; no ack is forwarded.
- IDLE:
  - If any m_wb_cyc_i is set, the search starts at (last+1) mod N and picks the first set bit.
  - On the next edge: owner and last take that index, state goes to BUSY.
  - Arbitration latency is 1 cycle from cyc assertion to grant.
  - If no request, stay in IDLE.
- BUSY, slave-side outputs:
  - s_wb_cyc_o = m_wb_cyc_i[owner].
  - s_wb_stb_o = m_wb_cyc_i[owner] & m_wb_stb_i[owner].
  - we, sel, adr and dat are muxed combinationally from owner.
- BUSY, master-side outputs:
  - m_wb_ack_o[owner] = s_wb_ack_i; all other acks are 0.
  - m_wb_dat_o = s_wb_dat_i in every state.
- BUSY, release:
  - When m_wb_cyc_i[owner]=0, go to IDLE on the next edge.
  - One dead cycle always follows a release before the next grant.
- Non-owner behaviour:
  - Strobes from non-owners are ignored; they see ack=0 and wait.
  - A master holding cyc across several strobes (block transfer) keeps the grant throughout.
- Outside BUSY: all s_wb_* outputs are 0.
- Simultaneous requests: resolved strictly by the rotating pointer; with N always requesting, each master is granted once per N grants.
- Owner drops cyc in the same cycle the slave acks: the ack is still forwarded that cycle, and the release follows the normal rule.
- Slave ack while the owner's stb is low (spurious): forwarded unchanged; the arbiter does not filter it.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter increments each BUSY cycle with s_wb_stb_o=1 and s_wb_ack_i=0.
  - It clears on ack, on release, and on reset.
  - When the counter equals TIMEOUT_CYCLES-1 and another stalled cycle occurs, m_wb_err_o[owner] pulses for exactly 1 cycle.
  - In that same cycle s_wb_stb_o is forced to 0, and the counter clears.
  - The grant is kept until the owner drops cyc.
- Not defined: no counter is built, and m_wb_err_o is tied to 0.

Test Plan:
- Reset, then M0 write (cyc=stb=we=1, sel=4'b0001, dat=32'h1): s_wb_stb_o rises 1 cycle later; the slave ack reaches m_wb_ack_o=2'b01 only.
- M0 and M1 assert cyc in the same cycle after reset: M0 is granted first. M0 drops cyc, there is 1 dead cycle, then M1 is granted. M1 is never acked during M0's transfer.
- N=3 with all masters requesting continuously (each drops cyc after 1 ack): grant order is 0,1,2,0,1,2.
- M1 holds cyc across 3 strobes: all 3 are acked to M1 while a pending M0 request waits. M0 is granted 2 cycles after M1 drops cyc.
- wb_rst_i asserted for 1 cycle while M1 is BUSY with the slave not yet acked: the next cycle shows s_wb_cyc_o=0 and all acks 0. A still-asserted M1 cyc is regranted 1 cycle after reset is released.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave never acks: m_wb_err_o[owner] pulses exactly once, s_wb_stb_o is 0 in that cycle, and the grant is held until cyc drops.
